// File: rtl/alu_pkg.sv
// Shared opcode, comparison-code and divider-state definitions for the ALU slice.
package alu_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_XOR    = 4'b0010;
    localparam logic [3:0] ALU_NOR    = 4'b0011;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0101;
    localparam logic [3:0] ALU_SLT    = 4'b0110;
    localparam logic [3:0] ALU_SLTU   = 4'b0111;
    localparam logic [3:0] ALU_SLL    = 4'b1000;
    localparam logic [3:0] ALU_SRL    = 4'b1001;
    localparam logic [3:0] ALU_SRA    = 4'b1010;
    localparam logic [3:0] ALU_LUI    = 4'b1011;
    localparam logic [3:0] ALU_DIVU_Q = 4'b1100;
    localparam logic [3:0] ALU_DIVU_R = 4'b1101;
    localparam logic [3:0] ALU_DIVS_Q = 4'b1110;
    localparam logic [3:0] ALU_DIVS_R = 4'b1111;

    localparam logic [1:0] COMP_EQ = 2'b00;
    localparam logic [1:0] COMP_GT = 2'b01;
    localparam logic [1:0] COMP_LT = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX
    } div_state_e;

    // Magnitude of a value, treating it as two's complement only in signed mode.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the execute stage and the ALU.
interface alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] out;
    logic [1:0]  comp;

    modport master (output a, b, ctrl, input out, comp);
    modport slave  (input a, b, ctrl, output out, comp);
endinterface

// File: rtl/alu_divider.sv
// Radix-4 restoring divider: load, 16 two-bit steps, then a sign fix-up cycle.
module alu_divider
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        divrst_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        signed_mode_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o
);

    div_state_e  state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] dvd_q;
    logic [31:0] dsr_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        dvz_q;
    logic [31:0] quo_out_q;
    logic [31:0] rem_out_q;
    logic        done_q;

    logic [33:0] shifted;
    logic [33:0] mul1, mul2, mul3;
    logic [33:0] diff;
    logic [1:0]  digit;
    logic [31:0] fix_quo, fix_rem;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_RUN:  if (cnt_q == 4'd15) state_d = DIV_FIX;
            DIV_FIX:  state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (divrst_i) state_d = DIV_RUN;
    end

    // dvd_q doubles as the quotient shift register: dividend bits leave at the top
    // while quotient digits enter at the bottom.
    always_comb begin
        shifted = {rem_q, dvd_q[31:30]};
        mul1    = {2'b00, dsr_q};
        mul2    = {1'b0, dsr_q, 1'b0};
        mul3    = mul1 + mul2;
        if (shifted >= mul3) begin
            digit = 2'd3;
            diff  = shifted - mul3;
        end else if (shifted >= mul2) begin
            digit = 2'd2;
            diff  = shifted - mul2;
        end else if (shifted >= mul1) begin
            digit = 2'd1;
            diff  = shifted - mul1;
        end else begin
            digit = 2'd0;
            diff  = shifted;
        end
        fix_quo = dvz_q ? '1 : (neg_quo_q ? -dvd_q : dvd_q);
        fix_rem = neg_rem_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk_i) begin
        state_q <= state_d;
        if (divrst_i) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= mag32(dividend_i, signed_mode_i);
            dsr_q     <= mag32(divisor_i, signed_mode_i);
            neg_quo_q <= signed_mode_i & (dividend_i[31] ^ divisor_i[31]);
            neg_rem_q <= signed_mode_i & dividend_i[31];
            dvz_q     <= (divisor_i == '0);
            quo_out_q <= '0;
            rem_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                DIV_RUN: begin
                    cnt_q <= cnt_q + 4'd1;
                    rem_q <= diff[31:0];
                    dvd_q <= {dvd_q[29:0], digit};
                end
                DIV_FIX: begin
                    quo_out_q <= fix_quo;
                    rem_out_q <= fix_rem;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign quotient_o  = quo_out_q;
    assign remainder_o = rem_out_q;
    assign done_o      = done_q;

endmodule

// File: rtl/alu.sv
// 32-bit MIPS-style ALU: combinational logic/arith/shift ops, signed compare,
// and registered divide results from the embedded divider.
module alu
    import alu_pkg::*;
(
    input  logic  clk_i,
    input  logic  divrst_i,
    alu_if.slave  bus
);

    logic [31:0] quo, rem;
    logic        div_done;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic [1:0]  cmp;

    alu_divider u_div (
        .clk_i         (clk_i),
        .divrst_i      (divrst_i),
        .dividend_i    (bus.a),
        .divisor_i     (bus.b),
        .signed_mode_i (bus.ctrl[1]),
        .quotient_o    (quo),
        .remainder_o   (rem),
        .done_o        (div_done)
    );

    assign shamt = bus.a[4:0];

    always_comb begin
        res = '0;
        case (bus.ctrl)
            ALU_AND:    res = bus.a & bus.b;
            ALU_OR:     res = bus.a | bus.b;
            ALU_XOR:    res = bus.a ^ bus.b;
            ALU_NOR:    res = ~(bus.a | bus.b);
            ALU_ADD:    res = bus.a + bus.b;
            ALU_SUB:    res = bus.a - bus.b;
            ALU_SLT:    res = {31'b0, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU:   res = {31'b0, (bus.a < bus.b)};
            ALU_SLL:    res = bus.b << shamt;
            ALU_SRL:    res = bus.b >> shamt;
            ALU_SRA:    res = $unsigned($signed(bus.b) >>> shamt);
            ALU_LUI:    res = {bus.b[15:0], 16'h0000};
            ALU_DIVU_Q,
            ALU_DIVS_Q: res = div_done ? quo : '0;
            ALU_DIVU_R,
            ALU_DIVS_R: res = div_done ? rem : '0;
            default:    res = '0;
        endcase
    end

    always_comb begin
        cmp = COMP_GT;
        if (bus.a == bus.b)
            cmp = COMP_EQ;
        else if ($signed(bus.a) < $signed(bus.b))
            cmp = COMP_LT;
    end

    assign bus.out  = res;
    assign bus.comp = cmp;

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic divrst;
    int unsigned n_checks;
    int unsigned n_pass;

    alu_if bus ();

    alu u_dut (
        .clk_i    (clk),
        .divrst_i (divrst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_comb(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh = int'(a % 32);
        fill = ~(32'hFFFF_FFFF >> sh);
        case (op)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_ADD:  return 32'(longint'(a) + longint'(b));
            ALU_SUB:  return 32'(longint'(a) - longint'(b));
            ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            ALU_SLL:  return 32'(longint'(b) * (longint'(1) << sh));
            ALU_SRL:  return 32'(longint'(b) / (longint'(1) << sh));
            ALU_SRA:  return (b >> sh) | (b[31] ? fill : 32'h0);
            ALU_LUI:  return b * 32'h0001_0000;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_comp(input logic [31:0] a, input logic [31:0] b);
        if (int'(a) == int'(b)) return {30'b0, COMP_EQ};
        if (int'(a) > int'(b))  return {30'b0, COMP_GT};
        return {30'b0, COMP_LT};
    endfunction

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    // Drives one full division; optionally scrambles inputs after the load edge.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input bit scramble);
        logic [31:0] eq, er;
        ref_div(a, b, sgn, eq, er);
        bus.a = a;
        bus.b = b;
        bus.ctrl = sgn ? ALU_DIVS_Q : ALU_DIVU_Q;
        divrst = 1'b1;
        @(posedge clk);
        #1 divrst = 1'b0;
        check({tag, "_clear"}, bus.out, 32'h0);
        if (scramble) begin
            bus.a = $urandom;
            bus.b = $urandom;
        end
        repeat (16) @(posedge clk);
        #1 check({tag, "_busy"}, bus.out, 32'h0);
        @(posedge clk);
        #1 check({tag, "_quo"}, bus.out, eq);
        bus.ctrl = sgn ? ALU_DIVS_R : ALU_DIVU_R;
        #1 check({tag, "_rem"}, bus.out, er);
        repeat (3) @(posedge clk);
        #1 check({tag, "_hold"}, bus.out, er);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  op;
        n_checks = 0;
        n_pass   = 0;
        divrst   = 1'b0;
        bus.a    = '0;
        bus.b    = '0;
        bus.ctrl = ALU_AND;
        @(negedge clk);

        run_div("d7_2u", 32'd7, 32'd2, 1'b0, 1'b0);
        run_div("dm7_2s", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run_div("dm7_2u", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_div("dz_u", 32'd5, 32'd0, 1'b0, 1'b0);
        run_div("dz_s", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);
        run_div("ovf_s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_div("max_u", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        run_div("big_u", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);

        // Abort: start 100/7, restart mid-run with 9/4.
        bus.a = 32'd100; bus.b = 32'd7; bus.ctrl = ALU_DIVU_Q; divrst = 1'b1;
        @(posedge clk); #1 divrst = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.a = 32'd9; bus.b = 32'd4; divrst = 1'b1;
        @(posedge clk); #1 divrst = 1'b0;
        repeat (16) @(posedge clk);
        #1 check("abort_busy", bus.out, 32'h0);
        @(posedge clk);
        #1 check("abort_quo", bus.out, 32'd2);
        bus.ctrl = ALU_DIVU_R;
        #1 check("abort_rem", bus.out, 32'd1);

        // divrst held high: completion counts from the last high sample.
        bus.a = 32'd100; bus.b = 32'd7; bus.ctrl = ALU_DIVU_Q; divrst = 1'b1;
        repeat (4) @(posedge clk);
        #1 divrst = 1'b0;
        repeat (16) @(posedge clk);
        #1 check("hold_busy", bus.out, 32'h0);
        @(posedge clk);
        #1 check("hold_quo", bus.out, 32'd14);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = rb >> $urandom_range(0, 31);
                1: ra = ra >> $urandom_range(0, 31);
                2: rb = 32'($urandom_range(0, 3)) - 32'd1;
                default: ;
            endcase
            run_div("rand_div", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        bus.ctrl = ALU_ADD; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
        #1 check("add_wrap", bus.out, 32'h0);
        bus.ctrl = ALU_SUB; bus.a = 32'd3; bus.b = 32'd5;
        #1 check("sub_neg", bus.out, 32'hFFFF_FFFE);
        bus.ctrl = ALU_SLT; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
        #1 check("slt", bus.out, 32'd1);
        #1 check("comp_lt", {30'b0, bus.comp}, 32'd2);
        bus.ctrl = ALU_SLTU;
        #1 check("sltu", bus.out, 32'd0);
        bus.ctrl = ALU_SRA; bus.a = 32'd4; bus.b = 32'h8000_0000;
        #1 check("sra", bus.out, 32'hF800_0000);
        bus.a = 32'd5; bus.b = 32'd5;
        #1 check("comp_eq", {30'b0, bus.comp}, 32'd0);
        bus.b = 32'hFFFF_FFFB;
        #1 check("comp_gt", {30'b0, bus.comp}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            op = 4'($urandom_range(0, 11));
            bus.a = ra; bus.b = rb; bus.ctrl = op;
            #1 check("rand_comb", bus.out, ref_comb(op, ra, rb));
            check("rand_comp", {30'b0, bus.comp}, ref_comp(ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
